sort_n_floats_seq: RTL

- Sequential sorter for N floating-point numbers, FLEN bits each, delivered as one vector through a valid/ready handshake.
- Sorts with a single f_less_or_equal instance. A bubble-sort FSM makes one comparison per cycle.
- Returns the vector in increasing order, plus a sticky error flag, through a valid/ready output handshake.
- Parametrised successor to the combinational two- and three-input float sorters. Trades latency for a single comparator instance.

---
 rtl/sort_n_floats_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sort_n_floats_seq.sv
// Sequential bubble sorter for N IEEE floats sharing one less-or-equal comparator.
// The result is registered in DONE and held until the consumer takes it.
package sort_cfg_pkg;
  localparam int FLEN = 64;
endpackage

module f_less_or_equal
  import sort_cfg_pkg::*;
(
  input  logic [FLEN-1:0] i_a,
  input  logic [FLEN-1:0] i_b,
  output logic            o_res,
  output logic            o_err
);
  localparam int EW = (FLEN == 32) ? 8 : 11;
  localparam int MW = FLEN - 1 - EW;

  logic [FLEN-2:0] w_mag_a, w_mag_b;
  logic            w_nan_a, w_nan_b;

  assign w_mag_a = i_a[FLEN-2:0];
  assign w_mag_b = i_b[FLEN-2:0];
  assign w_nan_a = (&i_a[FLEN-2:MW]) && (|i_a[MW-1:0]);
  assign w_nan_b = (&i_b[FLEN-2:MW]) && (|i_b[MW-1:0]);

  // Sign-magnitude compare; both zeros are equal regardless of sign.
  always_comb begin
    o_err = w_nan_a || w_nan_b;
    o_res = 1'b0;
    if (o_err)                                 o_res = 1'b0;
    else if (w_mag_a == '0 && w_mag_b == '0)   o_res = 1'b1;
    else if (i_a[FLEN-1] != i_b[FLEN-1])       o_res = i_a[FLEN-1];
    else if (!i_a[FLEN-1])                     o_res = (w_mag_a <= w_mag_b);
    else                                       o_res = (w_mag_a >= w_mag_b);
  end
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready; valid never
// waits on ready, ready/valid are decoded from registered state only.
module sort_n_floats_seq
  import sort_cfg_pkg::*;
#(
  parameter int N          = 4,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      up_valid,
  output logic                      up_ready,
  input  logic [0:N-1][FLEN-1:0]    unsorted,
  output logic                      down_valid,
  input  logic                      down_ready,
  output logic [0:N-1][FLEN-1:0]    sorted,
  output logic                      err,
  output logic [1:0]                o_dbg_state
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, SORT = 2'd1, DONE = 2'd2} state_t;

  state_t                   r_state, w_next;
  logic [0:N-1][FLEN-1:0]   r_buf, r_sorted;
  logic [CW-1:0]            r_idx, r_pass, w_idx_nx;
  logic                     r_swapped, r_err_sticky, r_err, r_last;
  logic [FLEN-1:0]          w_a, w_b;
  logic                     w_res, w_cmp_err, w_swap, w_pass_end, w_exit;

  assign w_idx_nx = r_idx + CW'(1);
  assign w_a      = r_buf[r_idx];
  assign w_b      = r_buf[w_idx_nx];

  f_less_or_equal u_cmp (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_res (w_res),
    .o_err (w_cmp_err)
  );

  // r_last marks that the final compare is done; the next cycle publishes the buffer.
  assign w_swap     = (r_state == SORT) && !r_last && !w_res && !w_cmp_err;
  assign w_pass_end = (r_idx == LAST);
  assign w_exit     = w_pass_end &&
                      ((r_pass == LAST) || (EARLY_EXIT && !r_swapped && !w_swap));

  assign up_ready    = (r_state == IDLE);
  assign down_valid  = (r_state == DONE);
  assign sorted      = r_sorted;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (up_valid)   w_next = SORT;
      SORT:    if (r_last)     w_next = DONE;
      DONE:    if (down_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf        <= '0;
      r_sorted     <= '0;
      r_idx        <= '0;
      r_pass       <= '0;
      r_swapped    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err        <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (up_valid) begin
          r_buf        <= unsorted;
          r_idx        <= '0;
          r_pass       <= '0;
          r_swapped    <= 1'b0;
          r_err_sticky <= 1'b0;
          r_last       <= 1'b0;
        end
        SORT: if (r_last) begin
          r_sorted <= r_buf;
          r_err    <= r_err_sticky;
          r_last   <= 1'b0;
        end else begin
          if (w_swap) begin
            r_buf[r_idx]    <= w_b;
            r_buf[w_idx_nx] <= w_a;
          end
          if (w_cmp_err) r_err_sticky <= 1'b1;
          if (w_pass_end) begin
            r_idx     <= '0;
            r_pass    <= r_pass + CW'(1);
            r_swapped <= 1'b0;
          end else begin
            r_idx <= w_idx_nx;
            if (w_swap) r_swapped <= 1'b1;
          end
          if (w_exit) r_last <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
